// File: rtl/fft_delay_line.sv
// Run-time programmable delay line for multi-channel sample streams with a shared
// valid tag: a ring of L-1 slots feeding a registered output, with stall and flush.
module fft_delay_line #(
    parameter int DATA_W    = 8,
    parameter int CH        = 2,
    parameter int MAX_DEPTH = 64,
    parameter int DEF_DEPTH = 8,
    parameter int DLY_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [DLY_W-1:0]     dly_cfg,
    input  logic [CH*DATA_W-1:0] din,
    input  logic                 vin,
    output logic [CH*DATA_W-1:0] dout,
    output logic                 vout,
    output logic [DLY_W-1:0]     cur_dly,
    output logic                 primed
);

    localparam int W     = CH * DATA_W;
    localparam int SLOTS = MAX_DEPTH - 1;
    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [W-1:0]       mem_q [SLOTS];
    logic [SLOTS-1:0]   tag_q, tag_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [DLY_W-1:0]   fill_q, fill_d, fill_inc;
    logic [W-1:0]       dout_q, dout_d;
    logic               vout_q, vout_d;
    logic               primed_q, primed_d;
    logic [DLY_W-1:0]   clamped;
    logic               adv;
    logic               single;
    logic               ptr_wrap;

    assign adv      = en & ~cfg_load;
    assign single   = (dly_q == DLY_W'(1));
    assign ptr_wrap = (DLY_W'(ptr_q) == (dly_q - DLY_W'(2)));
    assign fill_inc = (fill_q == dly_q) ? fill_q : fill_q + DLY_W'(1);

    always_comb begin
        clamped = dly_cfg;
        if (dly_cfg == '0) begin
            clamped = DLY_W'(1);
        end else if (dly_cfg > DLY_W'(MAX_DEPTH)) begin
            clamped = DLY_W'(MAX_DEPTH);
        end
    end

    // A flush keeps dout: with vout forced low its contents no longer matter.
    always_comb begin
        tag_d    = tag_q;
        ptr_d    = ptr_q;
        dly_d    = dly_q;
        fill_d   = fill_q;
        dout_d   = dout_q;
        vout_d   = vout_q;
        primed_d = primed_q;
        if (cfg_load) begin
            dly_d    = clamped;
            tag_d    = '0;
            ptr_d    = '0;
            fill_d   = '0;
            vout_d   = 1'b0;
            primed_d = 1'b0;
        end else if (en) begin
            if (single) begin
                dout_d = din;
                vout_d = vin;
            end else begin
                dout_d        = mem_q[ptr_q];
                vout_d        = tag_q[ptr_q];
                tag_d[ptr_q]  = vin;
                ptr_d         = ptr_wrap ? '0 : ptr_q + PTR_W'(1);
            end
            fill_d   = fill_inc;
            primed_d = (fill_inc == dly_q);
        end
    end

    // Sample storage carries no reset; its tags alone say whether it is live.
    always_ff @(posedge clk) begin
        if (adv && !single) begin
            mem_q[ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            ptr_q    <= '0;
            dly_q    <= DLY_W'(DEF_DEPTH);
            fill_q   <= '0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            ptr_q    <= ptr_d;
            dly_q    <= dly_d;
            fill_q   <= fill_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
            primed_q <= primed_d;
        end
    end

    assign dout    = dout_q;
    assign vout    = vout_q;
    assign cur_dly = dly_q;
    assign primed  = primed_q;

endmodule

// File: tb/tb_fft_delay_line.sv
// Scoreboarded bench for fft_delay_line: the reference keeps the last L accepted
// samples in a queue; the oldest one is what the output must show once L are held.
module tb_fft_delay_line;

    localparam int DATA_W    = 8;
    localparam int CH        = 2;
    localparam int MAX_DEPTH = 64;
    localparam int DEF_DEPTH = 8;
    localparam int DLY_W     = 7;
    localparam int W         = CH * DATA_W;

    typedef struct {
        logic [W-1:0] d;
        bit           v;
    } samp_t;

    typedef struct {
        logic [W-1:0]     d;
        bit               dk;
        bit               v;
        bit               p;
        logic [DLY_W-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_load;
    logic [DLY_W-1:0] dly_cfg;
    logic [W-1:0]     din;
    logic             vin;
    logic [W-1:0]     dout;
    logic             vout;
    logic [DLY_W-1:0] cur_dly;
    logic             primed;

    int    n_vec = 0;
    int    n_err = 0;
    int    n_txn = 0;
    exp_t  expq[$];

    int           L_m;
    samp_t        hist[$];
    logic [W-1:0] dout_m;
    bit           known_m;
    bit           vout_m;

    fft_delay_line #(
        .DATA_W(DATA_W), .CH(CH), .MAX_DEPTH(MAX_DEPTH),
        .DEF_DEPTH(DEF_DEPTH), .DLY_W(DLY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .dly_cfg(dly_cfg), .din(din), .vin(vin), .dout(dout),
        .vout(vout), .cur_dly(cur_dly), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        L_m     = DEF_DEPTH;
        hist.delete();
        dout_m  = '0;
        known_m = 1'b1;
        vout_m  = 1'b0;
    endtask

    task automatic model_edge(input bit e_i, input bit c_i, input logic [DLY_W-1:0] cv,
                              input logic [W-1:0] d_i, input bit v_i);
        samp_t s;
        if (c_i) begin
            L_m = (cv == 0) ? 1 : ((int'(cv) > MAX_DEPTH) ? MAX_DEPTH : int'(cv));
            hist.delete();
            vout_m = 1'b0;
        end else if (e_i) begin
            s.d = d_i;
            s.v = v_i;
            hist.push_back(s);
            if (hist.size() > L_m) void'(hist.pop_front());
            if (hist.size() == L_m) begin
                dout_m  = hist[0].d;
                vout_m  = hist[0].v;
                known_m = 1'b1;
            end else begin
                vout_m  = 1'b0;
                known_m = 1'b0;
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.d  = dout_m;
        e.dk = known_m;
        e.v  = vout_m;
        e.p  = (hist.size() == L_m);
        e.c  = DLY_W'(L_m);
        return e;
    endfunction

    task automatic step(input bit e_i, input bit c_i, input logic [DLY_W-1:0] cv,
                        input logic [W-1:0] d_i, input bit v_i);
        exp_t e;
        en       = e_i;
        cfg_load = c_i;
        dly_cfg  = cv;
        din      = d_i;
        vin      = v_i;
        model_edge(e_i, c_i, cv, d_i, v_i);
        e = snapshot();
        @(posedge clk);
        #1;
        expq.push_back(e);
    endtask

    task automatic stream(input int n, input int stall_pct);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(99) >= stall_pct, 1'b0, DLY_W'($urandom),
                 W'($urandom), 1'(($urandom_range(3)) != 0));
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        expq.push_back(snapshot());
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s txn %0d: got %h, expected %h", name, n_txn, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_txn++;
            $display("txn %0d: dout=%h vout=%b primed=%b cur_dly=%0d",
                     n_txn, dout, vout, primed, cur_dly);
            check("vout", W'(vout), W'(e.v));
            check("primed", W'(primed), W'(e.p));
            check("cur_dly", W'(cur_dly), W'(e.c));
            if (e.dk) check("dout", dout, e.d);
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        cfg_load = 1'b0;
        dly_cfg  = '0;
        din      = '0;
        vin      = 1'b0;
        model_reset();
        expq.push_back(snapshot());
        #12;
        rst_n = 1'b1;

        // single tagged sample at the default latency
        step(1'b1, 1'b0, '0, 16'hA53C, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, W'($urandom), 1'b0);

        // ramp with a stall window
        for (int i = 0; i < 24; i++) begin
            step(!(i >= 3 && i <= 5), 1'b0, '0, W'(i), 1'b1);
        end

        // shorten the line mid-stream
        stream(12, 0);
        step(1'b1, 1'b1, DLY_W'(3), W'($urandom), 1'b1);
        stream(15, 0);

        // clamping at both ends
        step(1'b0, 1'b1, DLY_W'(0), W'($urandom), 1'b1);
        stream(10, 0);
        step(1'b0, 1'b1, DLY_W'(100), W'($urandom), 1'b1);
        stream(90, 10);

        // flush wins over advance on the same edge
        step(1'b1, 1'b1, DLY_W'(8), 16'hBEEF, 1'b1);
        stream(20, 0);

        // asynchronous reset mid-stream
        stream(5, 0);
        async_reset();
        stream(20, 0);

        // randomised mix of stalls, reconfigurations and data
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) < 3) begin
                step(1'($urandom), 1'b1, DLY_W'($urandom_range(12)), W'($urandom), 1'b1);
            end else begin
                stream(1, 25);
            end
        end
        step(1'b0, 1'b1, DLY_W'(127), W'($urandom), 1'b0);
        stream(80, 5);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
